// File: rtl/riscv_multicycle_ctrl_if.sv
// riscv_multicycle_ctrl_if: IR fields, ALU flags, memory handshake and datapath controls of the multi-cycle controller
interface riscv_multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       N, Z, C, V;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       adr_sel;
  logic       ir_wren;
  logic       pc_wren;
  logic       regfile_wren;
  logic [1:0] ALU_asel;
  logic [1:0] ALU_bsel;
  logic [1:0] result_sel;
  logic [2:0] ximm_sel;
  logic [2:0] ALU_control;
  logic       fault;
  modport master (
    input  opcode, funct3, funct7b5, N, Z, C, V, mem_ready,
    output mem_req, mem_we, adr_sel, ir_wren, pc_wren, regfile_wren,
           ALU_asel, ALU_bsel, result_sel, ximm_sel, ALU_control, fault
  );
  modport slave (
    output opcode, funct3, funct7b5, N, Z, C, V, mem_ready,
    input  mem_req, mem_we, adr_sel, ir_wren, pc_wren, regfile_wren,
           ALU_asel, ALU_bsel, result_sel, ximm_sel, ALU_control, fault
  );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: Moore FSM sequencing a multi-cycle RV32I core; RISCV_MC_INSTRET_EN adds the instret counter
module riscv_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input logic                    clk,
  input logic                    reset_n,
  riscv_multicycle_ctrl_if.master bus
`ifdef RISCV_MC_INSTRET_EN
  ,
  output logic [CNT_W-1:0]       instret
`endif
);
  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [4:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXR, EXI,
    ALUWB, BRANCH, JAL, JALR1, JALR2, LUI, AUIPC, FAULT
  } state_t;
  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          waiting, timeout, ex_bad, br_bad, br_raw, br_take;
  logic [2:0]    ex_alu;
  assign waiting = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
  assign timeout = (MEM_TIMEOUT != 0) && (cnt_q == TW'(MEM_TIMEOUT));
  assign ex_bad  = bus.funct3[0] & ~&bus.funct3;
  assign ex_alu  = (bus.funct3 == 3'b010) ? 3'b101 :
                   (bus.funct3 == 3'b100) ? 3'b100 :
                   (bus.funct3 == 3'b110) ? 3'b011 :
                   (bus.funct3 == 3'b111) ? 3'b010 :
                   (bus.funct3 == 3'b000 && state_q == EXR && bus.funct7b5) ? 3'b001 : 3'b000;
  assign br_bad  = bus.funct3[2:1] == 2'b01;
  assign br_raw  = (bus.funct3[2:1] == 2'b00) ? bus.Z :
                   (bus.funct3[2:1] == 2'b10) ? (bus.N ^ bus.V) : ~bus.C;
  assign br_take = (br_raw ^ bus.funct3[0]) & ~br_bad;
  // Next state and Moore outputs; only FETCH and BRANCH write enables look at inputs
  always_comb begin
    state_d          = state_q;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.adr_sel      = 1'b0;
    bus.ir_wren      = 1'b0;
    bus.pc_wren      = 1'b0;
    bus.regfile_wren = 1'b0;
    bus.ALU_asel     = 2'b00;
    bus.ALU_bsel     = 2'b00;
    bus.result_sel   = 2'b00;
    bus.ximm_sel     = 3'b000;
    bus.ALU_control  = 3'b000;
    bus.fault        = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        bus.mem_req    = 1'b1;
        bus.ALU_bsel   = 2'b10;
        bus.result_sel = 2'b10;
        bus.ir_wren    = bus.mem_ready;
        bus.pc_wren    = bus.mem_ready;
        state_d        = bus.mem_ready ? DECODE : timeout ? FAULT : FETCH;
      end
      DECODE: begin
        bus.ALU_asel = 2'b01;
        bus.ALU_bsel = 2'b01;
        bus.ximm_sel = 3'b010;
        case (bus.opcode)
          7'b0000011, 7'b0100011: state_d = MEMADR;
          7'b0110011:             state_d = EXR;
          7'b0010011:             state_d = EXI;
          7'b1100011:             state_d = BRANCH;
          7'b1101111:             state_d = JAL;
          7'b1100111:             state_d = JALR1;
          7'b0110111:             state_d = LUI;
          7'b0010111:             state_d = AUIPC;
          default:                state_d = FAULT;
        endcase
      end
      MEMADR: begin
        bus.ALU_asel = 2'b10;
        bus.ALU_bsel = 2'b01;
        bus.ximm_sel = {2'b00, bus.opcode[5]};
        state_d      = bus.opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.adr_sel = 1'b1;
        state_d     = bus.mem_ready ? MEMWB : timeout ? FAULT : MEMREAD;
      end
      MEMWB: begin
        bus.result_sel   = 2'b01;
        bus.regfile_wren = 1'b1;
        state_d          = FETCH;
      end
      MEMWRITE: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.adr_sel = 1'b1;
        state_d     = bus.mem_ready ? FETCH : timeout ? FAULT : MEMWRITE;
      end
      EXR, EXI: begin
        bus.ALU_asel    = 2'b10;
        bus.ALU_bsel    = (state_q == EXI) ? 2'b01 : 2'b00;
        bus.ALU_control = ex_alu;
        state_d         = ex_bad ? FAULT : ALUWB;
      end
      ALUWB: begin
        bus.regfile_wren = 1'b1;
        state_d          = FETCH;
      end
      BRANCH: begin
        bus.ALU_asel    = 2'b10;
        bus.ALU_control = 3'b001;
        bus.pc_wren     = br_take;
        state_d         = br_bad ? FAULT : FETCH;
      end
      JAL: begin
        bus.ALU_asel = 2'b01;
        bus.ALU_bsel = 2'b10;
        bus.pc_wren  = 1'b1;
        state_d      = ALUWB;
      end
      JALR1: begin
        bus.ALU_asel   = 2'b10;
        bus.ALU_bsel   = 2'b01;
        bus.result_sel = 2'b10;
        bus.pc_wren    = 1'b1;
        state_d        = JALR2;
      end
      JALR2: begin
        bus.ALU_asel     = 2'b01;
        bus.ALU_bsel     = 2'b10;
        bus.result_sel   = 2'b10;
        bus.regfile_wren = 1'b1;
        state_d          = FETCH;
      end
      LUI, AUIPC: begin
        bus.ALU_asel = (state_q == LUI) ? 2'b11 : 2'b01;
        bus.ALU_bsel = 2'b01;
        bus.ximm_sel = 3'b100;
        state_d      = ALUWB;
      end
      FAULT:   bus.fault = 1'b1;
      default: state_d = FAULT;
    endcase
  end
  assign cnt_d = (waiting && !bus.mem_ready && state_d == state_q) ? cnt_q + TW'(1) : '0;
`ifdef RISCV_MC_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;
  assign instret_d = (state_d == FETCH && state_q != FETCH && state_q != IDLE) ?
                     instret_q + CNT_W'(1) : instret_q;
  assign instret   = instret_q;
`endif
  // State, memory-wait counter and retired count registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
`ifdef RISCV_MC_INSTRET_EN
      instret_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
`ifdef RISCV_MC_INSTRET_EN
      instret_q <= instret_d;
`endif
    end
  end
endmodule
